// File: rtl/rom_sweep_checker.sv
// rom_sweep_checker: self-checking ROM reader. Drives one address to the ROM under test and to a
// golden ROM, then compares the two read data streams.
// Run order: a sequential sweep of every address, then RANDOM_COUNT LFSR-driven reads, then a
// drain so that the last issued address is also compared.
//
// Ports:
//   clock0          sole clock, rising edge
//   global_resetn   asynchronous active-low reset
//   start           single-cycle run request (ignored while busy)
//   abort           stops a run at once; error results are kept
//   rom_addr        address shared by the ROM under test and the golden ROM
//   dut_data        read data from the ROM under test
//   exp_data        read data from the golden ROM (same latency)
//   busy            run in progress
//   done            run completed, held until the next start
//   pass            done with no mismatches
//   err_pulse       one-cycle pulse per mismatch
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatch
//   first_err_exp   golden data at the first mismatch
//   first_err_act   ROM-under-test data at the first mismatch
module rom_sweep_checker #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 7,    // at most 16, addresses come from the LFSR
    parameter int unsigned READ_LATENCY = 1,    // 0..3
    parameter int unsigned RANDOM_COUNT = 256,  // >= 1
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned ERR_WIDTH    = 16
) (
    input  logic                  clock0,
    input  logic                  global_resetn,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  err_pulse,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act
);

    localparam int unsigned CNT_WIDTH = (RANDOM_COUNT > 1) ? $clog2(RANDOM_COUNT) : 1;

    typedef enum logic [2:0] {StIdle, StSeq, StRand, StDrain, StDone} state_e;

    state_e                state;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [CNT_WIDTH-1:0]  rand_cnt;
    logic [1:0]            drain_cnt;

    // Stage 0 is the issued address itself; stage READ_LATENCY lines up with valid read data.
    logic [READ_LATENCY:0] vld_pipe;
    logic [ADDR_WIDTH-1:0] addr_pipe [READ_LATENCY+1];

    logic                  cmp_vld;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  mismatch;

    assign rom_addr = addr_pipe[0];

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    assign cmp_vld  = vld_pipe[READ_LATENCY];
    assign cmp_addr = addr_pipe[READ_LATENCY];
    assign mismatch = cmp_vld && (dut_data != exp_data);

    always_ff @(posedge clock0 or negedge global_resetn) begin
        if (!global_resetn) begin
            state          <= StIdle;
            lfsr           <= LFSR_SEED;
            rand_cnt       <= '0;
            drain_cnt      <= '0;
            vld_pipe       <= '0;
            for (int k = 0; k <= int'(READ_LATENCY); k++) begin
                addr_pipe[k] <= '0;
            end
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else begin
            for (int k = 1; k <= int'(READ_LATENCY); k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
            end

            // Registered compare stage.
            err_pulse <= mismatch;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_WIDTH'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= cmp_addr;
                    first_err_exp  <= exp_data;
                    first_err_act  <= dut_data;
                end
            end

            unique case (state)
                StIdle, StDone: begin
                    if (start && !abort) begin
                        state          <= StSeq;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_exp  <= '0;
                        first_err_act  <= '0;
                        lfsr           <= LFSR_SEED;
                        addr_pipe[0]   <= '0;
                        vld_pipe[0]    <= 1'b1;
                    end
                end
                StSeq: begin
                    if (addr_pipe[0] == '1) begin
                        // LFSR still holds the seed, so the first random address uses it.
                        state        <= StRand;
                        addr_pipe[0] <= lfsr[ADDR_WIDTH-1:0];
                        lfsr         <= lfsr_next;
                        rand_cnt     <= CNT_WIDTH'(RANDOM_COUNT - 1);
                    end else begin
                        addr_pipe[0] <= addr_pipe[0] + ADDR_WIDTH'(1);
                    end
                end
                StRand: begin
                    if (rand_cnt == '0) begin
                        state       <= StDrain;
                        vld_pipe[0] <= 1'b0;
                        drain_cnt   <= 2'(READ_LATENCY);
                    end else begin
                        addr_pipe[0] <= lfsr[ADDR_WIDTH-1:0];
                        lfsr         <= lfsr_next;
                        rand_cnt     <= rand_cnt - CNT_WIDTH'(1);
                    end
                end
                StDrain: begin
                    if (drain_cnt == 2'd0) begin
                        // Last compare landed on the previous edge, so err_count is final.
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= StIdle;
            endcase

            // Abort overrides everything above: drop in-flight compares, keep error results.
            if (abort && busy) begin
                state          <= StIdle;
                busy           <= 1'b0;
                done           <= 1'b0;
                pass           <= 1'b0;
                err_pulse      <= 1'b0;
                vld_pipe       <= '0;
                err_count      <= err_count;
                first_err_addr <= first_err_addr;
                first_err_exp  <= first_err_exp;
                first_err_act  <= first_err_act;
            end
        end
    end

endmodule
